dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory between the processor control unit (CPU port) and a host/loader port used for program and data preload and for debug inspection. It sits between the control unit's D_addr/D_wr path and the data RAM. It applies fixed CPU priority with a bounded host-starvation guard and a host lock mode for bursts. It also returns read data with the RAM's one-cycle read latency and tags each returned word with the port that issued the read.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 119 +++++++++++
 tb/tb_dmem_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of every signal crossing the arbiter boundary: CPU port, host port,
// shared RAM port, read return and lock status.
// The slave modport is the arbiter. The master modport is the surrounding
// environment: the two requesters plus the RAM.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              C_req;
   logic              C_wr;
   logic [ADDR_W-1:0] C_addr;
   logic [DATA_W-1:0] C_wdata;
   logic              C_gnt;
   logic              C_rvalid;

   logic              H_req;
   logic              H_wr;
   logic [ADDR_W-1:0] H_addr;
   logic [DATA_W-1:0] H_wdata;
   logic              H_lock;
   logic              H_gnt;
   logic              H_rvalid;

   logic [DATA_W-1:0] R_data;

   logic [ADDR_W-1:0] M_addr;
   logic              M_wr;
   logic [DATA_W-1:0] M_wdata;
   logic [DATA_W-1:0] M_rdata;

   logic              Locked;

   modport slave (
      input  C_req, C_wr, C_addr, C_wdata,
      input  H_req, H_wr, H_addr, H_wdata, H_lock,
      input  M_rdata,
      output C_gnt, C_rvalid, H_gnt, H_rvalid, R_data,
      output M_addr, M_wr, M_wdata, Locked
   );

   modport master (
      output C_req, C_wr, C_addr, C_wdata,
      output H_req, H_wr, H_addr, H_wdata, H_lock,
      output M_rdata,
      input  C_gnt, C_rvalid, H_gnt, H_rvalid, R_data,
      input  M_addr, M_wr, M_wdata, Locked
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU and the host/loader port.
// Policy: the CPU has fixed priority. A starvation counter forces a host win
// after STARVE_LIM consecutive losses. The host can also lock the arbiter for
// bursts. Each read returns one cycle later, tagged with the port that issued it.
module dmem_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 16,
   parameter int STARVE_LIM = 4
) (
   input  logic           Clk,
   input  logic           ResetN,
   dmem_arbiter_if.slave  bus
);

   typedef enum logic {ARB, HOST_LOCK} state_t;

   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   state_t            state_q, state_d;
   logic [3:0]        waitCnt_q, waitCnt_d;
   logic              cRvalid_q, hRvalid_q;
   logic              cGnt, hGnt;
   logic [ADDR_W-1:0] mAddr;
   logic [DATA_W-1:0] mWdata;
   logic              mWr;

   // State register; reset always drops back to arbitration, which releases any lock
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) state_q <= ARB;
      else         state_q <= state_d;
   end

   // Enter lock on a host transfer with H_lock set; leave on the first edge with H_lock clear
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB:       if (hGnt && bus.H_lock) state_d = HOST_LOCK;
         HOST_LOCK: if (!bus.H_lock)        state_d = ARB;
         default:   state_d = ARB;
      endcase
   end

   // Grants are combinational and held low while reset is asserted
   always_comb begin
      cGnt = 1'b0;
      hGnt = 1'b0;
      if (ResetN) begin
         case (state_q)
            ARB: begin
               if (bus.C_req && bus.H_req) begin
                  if (waitCnt_q == LIM) hGnt = 1'b1;
                  else                  cGnt = 1'b1;
               end else begin
                  cGnt = bus.C_req;
                  hGnt = bus.H_req;
               end
            end
            HOST_LOCK: hGnt = bus.H_req;
            default: begin
               cGnt = 1'b0;
               hGnt = 1'b0;
            end
         endcase
      end
   end

   // Starvation count: counts host losses in ARB, saturates at the limit, clears on any host transfer
   always_comb begin
      waitCnt_d = waitCnt_q;
      if (hGnt)
         waitCnt_d = 4'd0;
      else if ((state_q == ARB) && bus.H_req && (waitCnt_q != LIM))
         waitCnt_d = waitCnt_q + 4'd1;
   end

   // Starvation counter register
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) waitCnt_q <= 4'd0;
      else         waitCnt_q <= waitCnt_d;
   end

   // Owner tag for the read issued this cycle; reset drops any return still in flight
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         cRvalid_q <= 1'b0;
         hRvalid_q <= 1'b0;
      end else begin
         cRvalid_q <= cGnt && !bus.C_wr;
         hRvalid_q <= hGnt && !bus.H_wr;
      end
   end

   // RAM port follows whichever requester holds the grant; it is all-zero when idle
   always_comb begin
      mAddr  = '0;
      mWdata = '0;
      mWr    = 1'b0;
      if (cGnt) begin
         mAddr  = bus.C_addr;
         mWdata = bus.C_wdata;
         mWr    = bus.C_wr;
      end else if (hGnt) begin
         mAddr  = bus.H_addr;
         mWdata = bus.H_wdata;
         mWr    = bus.H_wr;
      end
   end

   assign bus.C_gnt    = cGnt;
   assign bus.H_gnt    = hGnt;
   assign bus.M_addr   = mAddr;
   assign bus.M_wdata  = mWdata;
   assign bus.M_wr     = mWr;
   assign bus.C_rvalid = cRvalid_q;
   assign bus.H_rvalid = hRvalid_q;
   assign bus.R_data   = (cRvalid_q || hRvalid_q) ? bus.M_rdata : '0;
   assign bus.Locked   = (state_q == HOST_LOCK);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by a random run.
// Every cycle is compared against a behavioural model kept in the bench: a
// lock flag, a host-loss count, a shadow memory and the pending read return.
module tb_dmem_arbiter;

   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 16;
   localparam int STARVE_LIM = 4;

   logic Clk    = 1'b0;
   logic ResetN = 1'b1;

   int vectors     = 0;
   int miscompares = 0;

   bit          mLocked;
   int          mWait;
   bit          mPendC, mPendH;
   logic [15:0] mRdata;
   logic [15:0] refMem [256];
   logic [15:0] ram    [256];

   dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busIf ();

   dmem_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .STARVE_LIM(STARVE_LIM)
   ) dut (
      .Clk(Clk),
      .ResetN(ResetN),
      .bus(busIf)
   );

   // Clock generation
   always #5 Clk = ~Clk;

   // Behavioural single-port RAM with a one-cycle synchronous read
   always @(posedge Clk) begin
      busIf.M_rdata <= ram[busIf.M_addr];
      if (busIf.M_wr) ram[busIf.M_addr] <= busIf.M_wdata;
   end

   // One comparison: counts it and reports the observed and expected values on mismatch
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, check every output against the model, then advance the model over the edge
   task automatic applyStimulus(
      input bit rst,
      input bit cReq, input bit cWr, input logic [7:0] cAddr, input logic [15:0] cWdata,
      input bit hReq, input bit hWr, input bit hLock, input logic [7:0] hAddr,
      input logic [15:0] hWdata);
      bit          eC, eH, eWr;
      logic [7:0]  eAddr;
      logic [15:0] eWdata;
      ResetN        = rst;
      busIf.C_req   = cReq;
      busIf.C_wr    = cWr;
      busIf.C_addr  = cAddr;
      busIf.C_wdata = cWdata;
      busIf.H_req   = hReq;
      busIf.H_wr    = hWr;
      busIf.H_lock  = hLock;
      busIf.H_addr  = hAddr;
      busIf.H_wdata = hWdata;
      if (!rst) begin
         mLocked = 1'b0;
         mWait   = 0;
         mPendC  = 1'b0;
         mPendH  = 1'b0;
      end
      #1;
      eC = 1'b0;
      eH = 1'b0;
      if (rst) begin
         if (mLocked)
            eH = hReq;
         else if (cReq && hReq) begin
            if (mWait == STARVE_LIM) eH = 1'b1;
            else                     eC = 1'b1;
         end else begin
            eC = cReq;
            eH = hReq;
         end
      end
      eAddr  = 8'h00;
      eWdata = 16'h0000;
      eWr    = 1'b0;
      if (eC) begin
         eAddr = cAddr; eWdata = cWdata; eWr = cWr;
      end else if (eH) begin
         eAddr = hAddr; eWdata = hWdata; eWr = hWr;
      end
      checkOutput("C_gnt",    32'(busIf.C_gnt),    32'(eC));
      checkOutput("H_gnt",    32'(busIf.H_gnt),    32'(eH));
      checkOutput("M_wr",     32'(busIf.M_wr),     32'(eWr));
      checkOutput("M_addr",   32'(busIf.M_addr),   32'(eAddr));
      checkOutput("M_wdata",  32'(busIf.M_wdata),  32'(eWdata));
      checkOutput("C_rvalid", 32'(busIf.C_rvalid), 32'(mPendC));
      checkOutput("H_rvalid", 32'(busIf.H_rvalid), 32'(mPendH));
      checkOutput("R_data",   32'(busIf.R_data),   (mPendC || mPendH) ? 32'(mRdata) : 32'd0);
      checkOutput("Locked",   32'(busIf.Locked),   32'(mLocked));
      @(posedge Clk);
      if (rst) begin
         if (eC && !cWr) mRdata = refMem[cAddr];
         if (eH && !hWr) mRdata = refMem[hAddr];
         mPendC = eC && !cWr;
         mPendH = eH && !hWr;
         if (eC && cWr) refMem[cAddr] = cWdata;
         if (eH && hWr) refMem[hAddr] = hWdata;
         if (eH)
            mWait = 0;
         else if (!mLocked && hReq && (mWait < STARVE_LIM))
            mWait++;
         if (!mLocked && eH && hLock)
            mLocked = 1'b1;
         else if (mLocked && !hLock)
            mLocked = 1'b0;
      end
      @(negedge Clk);
   endtask

   // Directed scenarios, then randomized traffic with occasional resets
   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]    = 16'h0000;
         refMem[i] = 16'h0000;
      end
      mLocked = 1'b0;
      mWait   = 0;
      mPendC  = 1'b0;
      mPendH  = 1'b0;
      mRdata  = 16'h0000;

      // Reset held with both ports requesting
      applyStimulus(0, 1, 0, 8'h10, 16'h0, 1, 1, 0, 8'h10, 16'h1234);
      applyStimulus(0, 1, 0, 8'h10, 16'h0, 1, 1, 0, 8'h10, 16'h1234);

      // Sustained conflict: CPU wins four times, the host write wins the fifth, then the CPU reads it back
      for (int i = 0; i < 7; i++)
         applyStimulus(1, 1, 0, 8'h10, 16'h0, (i < 5), 1, 0, 8'h10, 16'h1234);
      applyStimulus(1, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);

      // Lone CPU read of 0x10
      applyStimulus(1, 1, 0, 8'h10, 16'h0, 0, 0, 0, 8'h00, 16'h0);
      applyStimulus(1, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);

      // Host lock burst writing 0xA0..0xA3 to 0..3 while the CPU keeps asking
      applyStimulus(1, 0, 0, 8'h02, 16'h0, 1, 1, 1, 8'h00, 16'h00A0);
      for (int i = 1; i < 4; i++)
         applyStimulus(1, 1, 0, 8'h02, 16'h0, 1, 1, 1, 8'(i), 16'(16'h00A0 + i));
      applyStimulus(1, 1, 0, 8'h02, 16'h0, 0, 0, 0, 8'h00, 16'h0);
      applyStimulus(1, 1, 0, 8'h02, 16'h0, 0, 0, 0, 8'h00, 16'h0);
      applyStimulus(1, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);

      // Interleaved reads: CPU then host on consecutive cycles
      applyStimulus(1, 1, 0, 8'h03, 16'h0, 0, 0, 0, 8'h00, 16'h0);
      applyStimulus(1, 0, 0, 8'h00, 16'h0, 1, 0, 0, 8'h01, 16'h0);
      applyStimulus(1, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
      applyStimulus(1, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);

      // H_lock without a request must not lock
      applyStimulus(1, 0, 0, 8'h00, 16'h0, 0, 0, 1, 8'h00, 16'h0);
      applyStimulus(1, 0, 0, 8'h00, 16'h0, 0, 0, 1, 8'h00, 16'h0);

      // Reset arriving while a CPU read return is pending
      applyStimulus(1, 1, 0, 8'h02, 16'h0, 0, 0, 0, 8'h00, 16'h0);
      applyStimulus(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
      applyStimulus(1, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);

      // Reset while locked releases the lock
      applyStimulus(1, 0, 0, 8'h00, 16'h0, 1, 1, 1, 8'h05, 16'hBEEF);
      applyStimulus(1, 1, 0, 8'h05, 16'h0, 0, 0, 1, 8'h00, 16'h0);
      applyStimulus(0, 1, 0, 8'h05, 16'h0, 0, 0, 1, 8'h00, 16'h0);
      applyStimulus(1, 1, 0, 8'h05, 16'h0, 0, 0, 1, 8'h00, 16'h0);
      applyStimulus(1, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);

      // Randomized traffic on a small address window
      for (int i = 0; i < 400; i++) begin
         applyStimulus(
            ($urandom_range(0, 63) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 15)), 16'($urandom));
      end
      applyStimulus(1, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
